// File: rtl/contador_pkg.sv
// Shared types and defaults for the up/down counter family.
package contador_pkg;

    // Width used when a counter is instantiated without overriding N.
    localparam int CONTADOR_ANCHO_DEF = 4;

    // IDLE: holding, waiting for a load
    // COUNT: decrementing towards zero
    // EXPIRED: one-shot finished, Q parked at zero
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } estado_t;

endpackage : contador_pkg

// File: rtl/contador_descendente_n_bits.sv
// Programmable N-bit down-counter/timer with one-cycle terminal-count pulse
// and optional auto-reload for periodic ticks.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | Q holds its value; only a load moves us on
//   COUNT   | Q decrements on en; expiry at Q==1 pulses tc
//   EXPIRED | one-shot done, Q forced to 0, en ignored until load/clr
module contador_descendente_n_bits
    import contador_pkg::*;
#(
    parameter int N = CONTADOR_ANCHO_DEF
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] valor,
    input  logic         en,
    input  logic         auto_recarga,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         activo,
    output logic         expirado
);

    localparam logic [N-1:0] CERO = '0;
    localparam logic [N-1:0] UNO  = N'(1);

    estado_t      estado;
    estado_t      estado_sig;
    logic [N-1:0] cuenta_sig;
    logic [N-1:0] recarga;
    logic [N-1:0] recarga_sig;
    logic         tc_sig;

    // Next-state, next-count and terminal-count decision; load beats counting.
    always_comb begin
        estado_sig  = estado;
        cuenta_sig  = Q;
        recarga_sig = recarga;
        tc_sig      = 1'b0;

        if (load) begin
            recarga_sig = valor;
            cuenta_sig  = valor;
            // A zero load has nothing to count, so it parks in IDLE.
            estado_sig  = (valor != CERO) ? COUNT : IDLE;
        end else begin
            case (estado)
                IDLE: begin
                    estado_sig = IDLE;
                end
                COUNT: begin
                    if (en) begin
                        if (Q == UNO) begin
                            tc_sig = 1'b1;
                            if (auto_recarga) begin
                                cuenta_sig = recarga;
                            end else begin
                                cuenta_sig = CERO;
                                estado_sig = EXPIRED;
                            end
                        end else if (Q != CERO) begin
                            cuenta_sig = Q - UNO;
                        end
                        // Q==0 in COUNT is unreachable; never decrement
                        // from zero so the counter cannot wrap.
                    end
                end
                EXPIRED: begin
                    cuenta_sig = CERO;
                end
                default: begin
                    estado_sig = IDLE;
                    cuenta_sig = CERO;
                end
            endcase
        end
    end

    // State, count, reload and registered flag outputs; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            estado   <= IDLE;
            Q        <= CERO;
            recarga  <= CERO;
            tc       <= 1'b0;
            activo   <= 1'b0;
            expirado <= 1'b0;
        end else begin
            estado   <= estado_sig;
            Q        <= cuenta_sig;
            recarga  <= recarga_sig;
            tc       <= tc_sig;
            activo   <= (estado_sig == COUNT);
            expirado <= (estado_sig == EXPIRED);
        end
    end

endmodule : contador_descendente_n_bits

// File: tb/tb_contador_descendente_n_bits.sv
// Self-checking bench for contador_descendente_n_bits: a reference model
// pushes expected outputs per cycle, which are popped and compared after
// the edge.
module tb_contador_descendente_n_bits;
    import contador_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] q;
        logic         tc;
        logic         act;
        logic         exp;
    } salida_t;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         load = 1'b0;
    logic [N-1:0] valor = '0;
    logic         en = 1'b0;
    logic         auto_recarga = 1'b0;
    logic [N-1:0] Q;
    logic         tc;
    logic         activo;
    logic         expirado;

    int n_vec = 0;
    int n_err = 0;

    salida_t cola[$];

    estado_t      m_est = IDLE;
    logic [N-1:0] m_q = '0;
    logic [N-1:0] m_rec = '0;
    logic         m_tc = 1'b0;

    contador_descendente_n_bits #(.N(N)) dut (
        .clk          (clk),
        .clr          (clr),
        .load         (load),
        .valor        (valor),
        .en           (en),
        .auto_recarga (auto_recarga),
        .Q            (Q),
        .tc           (tc),
        .activo       (activo),
        .expirado     (expirado)
    );

    always #5 clk = ~clk;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_vec++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs, then compare after the edge.
    task automatic ciclo(input logic c, input logic l, input logic [N-1:0] v,
                         input logic e, input logic a, input string tag);
        salida_t esp;
        clr = c; load = l; valor = v; en = e; auto_recarga = a;
        m_tc = 1'b0;
        if (c) begin
            m_q = '0; m_rec = '0; m_est = IDLE;
        end else if (l) begin
            m_q = v; m_rec = v;
            m_est = (v != '0) ? COUNT : IDLE;
        end else if (m_est == COUNT && e) begin
            if (m_q == 4'd1) begin
                m_tc = 1'b1;
                if (a) m_q = m_rec;
                else begin
                    m_q = '0; m_est = EXPIRED;
                end
            end else if (m_q > 4'd1) begin
                m_q = m_q - 1'b1;
            end
        end else if (m_est == EXPIRED) begin
            m_q = '0;
        end
        cola.push_back('{q: m_q, tc: m_tc, act: (m_est == COUNT), exp: (m_est == EXPIRED)});
        @(posedge clk);
        #1;
        esp = cola.pop_front();
        chequear({tag, ".q"}, 32'(Q), 32'(esp.q));
        chequear({tag, ".flags"}, 32'({tc, activo, expirado}), 32'({esp.tc, esp.act, esp.exp}));
    endtask

    initial begin
        int n_tc;
        int borde_tc;

        // 1: reset for two edges, then IDLE holds with no load
        ciclo(1, 0, 4'd0, 0, 0, "rst");
        ciclo(1, 1, 4'd9, 1, 1, "rst");
        chequear("rst.q_cero", 32'(Q), 32'd0);
        for (int i = 0; i < 5; i++) ciclo(0, 0, 4'd7, 1, 0, "idle");

        // 2: one-shot of 5; tc on the 5th edge, then EXPIRED held
        ciclo(0, 1, 4'd5, 1, 0, "os_load");
        chequear("os_load.q5", 32'(Q), 32'd5);
        borde_tc = -1;
        for (int i = 1; i <= 5; i++) begin
            ciclo(0, 0, 4'd0, 1, 0, "os_cnt");
            if (tc) borde_tc = i;
        end
        chequear("os_tc_edge", 32'(borde_tc), 32'd5);
        n_tc = 0;
        for (int i = 0; i < 10; i++) begin
            ciclo(0, 0, 4'd0, 1, i[0], "os_exp");
            if (tc) n_tc++;
        end
        chequear("os_exp_no_tc", 32'(n_tc), 32'd0);
        chequear("os_exp_flag", 32'(expirado), 32'd1);

        // 3: load 5, pause 3 cycles at Q=3, tc 8 edges after load
        ciclo(0, 1, 4'd5, 1, 0, "pause_load");
        borde_tc = -1;
        for (int i = 1; i <= 12; i++) begin
            ciclo(0, 0, 4'd0, !(i >= 3 && i <= 5), 0, "pause");
            if (i == 5) chequear("pause_hold3", 32'(Q), 32'd3);
            if (tc && borde_tc < 0) borde_tc = i;
        end
        chequear("pause_tc_edge", 32'(borde_tc), 32'd8);

        // 4: auto-reload of 3 for 12 enabled cycles -> 4 pulses
        ciclo(0, 1, 4'd3, 1, 1, "auto_load");
        n_tc = 0;
        for (int i = 0; i < 12; i++) begin
            ciclo(0, 0, 4'd0, 1, 1, "auto");
            if (tc) n_tc++;
        end
        chequear("auto_pulses", 32'(n_tc), 32'd4);
        chequear("auto_q_reload", 32'(Q), 32'd3);

        // 5: reload mid-count, then load of zero
        ciclo(0, 1, 4'd4, 1, 0, "rl_load");
        ciclo(0, 0, 4'd0, 1, 0, "rl_cnt");
        ciclo(0, 0, 4'd0, 1, 0, "rl_cnt");
        chequear("rl_q2", 32'(Q), 32'd2);
        ciclo(0, 1, 4'd15, 1, 0, "rl_15");
        chequear("rl_q15", 32'(Q), 32'd15);
        ciclo(0, 1, 4'd0, 1, 0, "rl_0");
        for (int i = 0; i < 3; i++) ciclo(0, 0, 4'd0, 1, 0, "rl_idle");

        // 6a: clr coincident with load
        ciclo(0, 1, 4'd6, 1, 0, "cl_pre");
        ciclo(1, 1, 4'd9, 1, 0, "cl_load");
        ciclo(0, 0, 4'd0, 1, 0, "cl_after");
        // 6b: clr on the expiry edge
        ciclo(0, 1, 4'd2, 1, 0, "ce_load");
        ciclo(0, 0, 4'd0, 1, 0, "ce_q1");
        ciclo(1, 0, 4'd0, 1, 0, "ce_clr");
        ciclo(0, 0, 4'd0, 1, 0, "ce_after");
        // 6c: full range 15 -> 0, no wrap
        ciclo(0, 1, 4'd15, 1, 0, "full_load");
        borde_tc = -1;
        for (int i = 1; i <= 20; i++) begin
            ciclo(0, 0, 4'd0, 1, 0, "full");
            if (tc) borde_tc = i;
        end
        chequear("full_tc_edge", 32'(borde_tc), 32'd15);
        chequear("full_no_wrap", 32'(Q), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_contador_descendente_n_bits

// File: doc/contador_descendente_n_bits.md
Name: contador_descendente_n_bits

Overview:
Programmable N-bit down-counter/timer. It is the counterpart to the up-counting contador_n_bits: it is loaded with a value and counts toward zero. It signals expiry with a one-cycle terminal-count pulse and can auto-reload for periodic ticks. It feeds timing and delay generation elsewhere in the design.

Parameters:
N, 4, counter width in bits; loadable range 0..2^N-1

Ports:
clk  input  1  clock; all state changes on rising edge
clr  input  1  synchronous active-high reset
load  input  1  one-cycle strobe: capture valor into count and reload register
valor  input  N  load value
en  input  1  count enable; decrement only when high
auto_recarga  input  1  1 = reload from reload register on expiry; 0 = one-shot
Q  output  N  current count (registered)
tc  output  1  terminal-count pulse (registered, one cycle)
activo  output  1  high while in COUNT state
expirado  output  1  high while in EXPIRED state

Behaviour:
- Reset: one clock, synchronous, active-high. clr=1 at a rising edge forces the following, regardless of any other input:
  - Q=0, tc=0, activo=0, expirado=0
  - reload register=0
  - state=IDLE
- Priority at each edge: clr > load > count/expiry logic.
- States:
  - IDLE: Q holds. Exits only on load.
  - COUNT: activo=1.
  - EXPIRED: expirado=1; Q=0.
- load=1 (any state):
  - reload register <= valor; Q <= valor.
  - valor!=0 -> COUNT. valor==0 -> IDLE.
  - tc=0 that cycle. Any in-progress count is discarded.
- COUNT with en=0: Q holds, tc=0.
- COUNT with en=1 and Q>1: Q <= Q-1, tc=0.
- COUNT with en=1 and Q==1 (expiry):
  - auto_recarga=0: Q <= 0, tc <= 1, state -> EXPIRED.
  - auto_recarga=1: Q <= reload register, tc <= 1, stay in COUNT. Period equals the reload value in enabled cycles.
- tc is high for exactly the one cycle following the expiry edge, then 0. tc is never asserted by load or clr.
- EXPIRED: Q stays 0 and en is ignored. Exits only on load or clr.
- No wrap-around: Q never goes from 0 to 2^N-1. A decrement is never applied when Q==0.
- auto_recarga is sampled only at the expiry edge. It may change freely otherwise.
- Loading 2^N-1 is legal; the full range counts down correctly.
- clr mid-count, or coincident with expiry, suppresses tc and returns to IDLE.
- Latency: load -> Q valid next cycle. With en held high, a load of V gives tc exactly V edges after the load edge.

Decomposition:
- Shared package contador_pkg holds:
  - typedef enum logic [1:0] estado_t {IDLE, COUNT, EXPIRED}
  - a localparam default width of 4, shared with contador_n_bits
- No sub-module. One state register, one count register and one reload register in a single always_ff, with combinational next-state logic. Expected size is about 120-150 lines.

Test Plan:
1. N=4, clr=1 for 2 edges, then 0 -> Q=0, tc=0, activo=0, expirado=0; state IDLE held for 5 edges with load=0.
2. load valor=5, en=1, auto_recarga=0 -> Q sequence 5,4,3,2,1,0; tc=1 for one cycle when Q first reads 0; then expirado=1, activo=0, Q=0 held 10 cycles with en=1.
3. load 5, en=1, drop en for 3 cycles when Q=3 -> Q holds 3 for 3 cycles and tc stays 0; resume; tc after 8 total edges from load.
4. auto_recarga=1, load 3, en=1 for 12 cycles -> Q 3,2,1,3,2,1,...; tc pulses every 3 cycles (4 pulses); expirado stays 0.
5. Count running with Q=2, load valor=15 -> Q=15 next edge, no tc. Then load valor=0 -> Q=0, IDLE, activo=0, expirado=0, no tc.
6. clr=1 on the same edge as load=1 and, separately, on the edge where Q==1 with en=1 -> Q=0, IDLE, tc=0 both cases. Also check that load of 15 counts to 0 in 15 edges with no wrap to 15.
